// File: rtl/sensor_lm07_multi.sv
// Multi-channel LM07-style serial temperature sensor slave: a command on sdi selects a
// channel word or the alert-flag word, which is then shifted out MSB first on sio.
module sensor_lm07_multi #(
    parameter int DATA_W = 10,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     sdi,
    input  logic [NUM_CH*DATA_W-1:0] temp_in,
    input  logic [DATA_W-1:0]        alert_limit,
    output logic                     sio,
    output logic [NUM_CH-1:0]        alert,
    output logic                     busy
);

    localparam int CMD_W   = CH_W + 1;
    localparam int CNT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CMD_W-2:0]        cmd, cmd_nxt;
    logic [CMD_W-1:0]        cmd_shift;
    logic [DATA_W-1:0]       shreg, shreg_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic [NUM_CH-1:0]       over, alert_nxt;
    logic [DATA_W-1:0]       chan_word, alert_word;
    logic signed [DATA_W-1:0] limit_s;
    logic signed [DATA_W-1:0] temp_s [NUM_CH];
    logic                    load_edge, mode_bit;
    logic [CH_W-1:0]         ch_sel;

    assign limit_s   = alert_limit;
    // Full command as it stands on the edge that samples the current sdi bit
    assign cmd_shift = {cmd, sdi};
    assign mode_bit  = cmd_shift[CMD_W-1];
    assign ch_sel    = cmd_shift[CH_W-1:0];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            temp_s[i] = temp_in[i*DATA_W +: DATA_W];
            over[i]   = temp_s[i] > limit_s;
        end
    end

    // Channels at or beyond NUM_CH match nothing and fall through to the all-ones error word
    always_comb begin
        chan_word  = '1;
        alert_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i))
                chan_word = temp_in[i*DATA_W +: DATA_W];
            alert_word[i] = alert[i];
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        shreg_nxt = shreg;
        count_nxt = count;
        load_edge = 1'b0;
        if (cs) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_nxt   = (CMD_W-1)'(sdi);
                    count_nxt = CNT_W'(1);
                    state_nxt = CMD;
                end
                CMD: begin
                    cmd_nxt   = cmd_shift[CMD_W-2:0];
                    count_nxt = count + CNT_W'(1);
                    if (count == CNT_W'(CMD_W - 1)) begin
                        load_edge = 1'b1;
                        shreg_nxt = mode_bit ? alert_word : chan_word;
                        count_nxt = '0;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                    count_nxt = count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end
                end
                default: ;
            endcase
        end
        // A flag-word read re-arms the flags; a channel still over re-sets in the same edge
        alert_nxt = (load_edge && mode_bit) ? over : (alert | over);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state <= IDLE;
            cmd   <= '0;
            shreg <= '0;
            count <= '0;
            alert <= '0;
        end else begin
            state <= state_nxt;
            cmd   <= cmd_nxt;
            shreg <= shreg_nxt;
            count <= count_nxt;
            alert <= alert_nxt;
        end
    end

    assign sio  = (state == DATA) ? shreg[DATA_W-1] : 1'b0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sensor_lm07_multi.sv
// Directed bench for sensor_lm07_multi: a 4-channel and a 3-channel instance share the
// serial bus; table-driven reads plus hand-written alert, abort and reset sequences.
module tb_sensor_lm07_multi;

    logic        sclk = 1'b0;
    logic        reset, cs, sdi;
    logic [39:0] temp_in;
    logic [9:0]  alert_limit;
    logic        sio, busy, sio3, busy3;
    logic [3:0]  alert;
    logic [2:0]  alert3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [39:0] temps;
        logic [9:0]  exp4;
        logic [9:0]  exp3;
    } vec_t;

    vec_t vecs [5];

    sensor_lm07_multi #(.DATA_W(10), .NUM_CH(4), .CH_W(2)) dut4 (
        .sclk(sclk), .reset(reset), .cs(cs), .sdi(sdi), .temp_in(temp_in),
        .alert_limit(alert_limit), .sio(sio), .alert(alert), .busy(busy)
    );

    sensor_lm07_multi #(.DATA_W(10), .NUM_CH(3), .CH_W(2)) dut3 (
        .sclk(sclk), .reset(reset), .cs(cs), .sdi(sdi), .temp_in(temp_in[29:0]),
        .alert_limit(alert_limit), .sio(sio3), .alert(alert3), .busy(busy3)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sdi = c[2-i];
            step();
            check("busy_cmd", busy, 1'b1);
        end
    endtask

    task automatic read_frame(input logic [2:0] c, output logic [9:0] w4, output logic [9:0] w3,
                              output logic [3:0] al4, output logic [2:0] al3);
        send_cmd(c);
        al4 = alert;
        al3 = alert3;
        for (int b = 9; b >= 0; b--) begin
            w4[b] = sio;
            w3[b] = sio3;
            check("busy_data", busy, 1'b1);
            sdi = ~sdi;
            step();
        end
        check("sio_done", sio, 1'b0);
        check("sio3_done", sio3, 1'b0);
        check("busy_done", busy, 1'b1);
        cs = 1'b1;
        step();
        check("busy_idle", busy, 1'b0);
        check("sio_idle", sio, 1'b0);
    endtask

    initial begin
        logic [9:0] w4, w3, part;
        logic [3:0] al4;
        logic [2:0] al3;

        vecs[0] = '{3'b010, {10'h3FB, 10'b1101011011, 10'h200, 10'h155}, 10'b1101011011, 10'b1101011011};
        vecs[1] = '{3'b011, {10'h3FB, 10'b1101011011, 10'h200, 10'h155}, 10'h3FB, 10'h3FF};
        vecs[2] = '{3'b000, {10'h3FB, 10'b1101011011, 10'h200, 10'h155}, 10'h155, 10'h155};
        vecs[3] = '{3'b001, {10'h3FB, 10'b1101011011, 10'h200, 10'h155}, 10'h200, 10'h200};
        vecs[4] = '{3'b100, {10'h3FB, 10'b1101011011, 10'h200, 10'h155}, 10'h000, 10'h000};

        reset = 1'b1; cs = 1'b0; sdi = 1'b0; temp_in = '0; alert_limit = '0;

        // Reset held with cs low and sdi toggling
        for (int i = 0; i < 2; i++) begin
            sdi = ~sdi;
            step();
        end
        check("rst_sio", sio, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alert", alert, 4'b0);
        check("rst_busy3", busy3, 1'b0);
        reset = 1'b0; cs = 1'b1;
        step();
        check("rel_busy", busy, 1'b0);

        // Table-driven reads; limit at max positive so no flag ever sets
        for (int v = 0; v < 5; v++) begin
            temp_in     = vecs[v].temps;
            alert_limit = 10'h1FF;
            read_frame(vecs[v].cmd, w4, w3, al4, al3);
            check($sformatf("word4_v%0d", v), w4, vecs[v].exp4);
            check($sformatf("word3_v%0d", v), w3, vecs[v].exp3);
            check($sformatf("alert_v%0d", v), al4, 4'b0);
        end

        // Sticky alerts with signed compare and clear-on-read
        alert_limit = 10'd100;
        temp_in = {10'h3FB, 10'd0, 10'd120, 10'd0};
        cs = 1'b1;
        step();
        check("alert_set", alert, 4'b0010);
        check("alert3_set", alert3, 3'b010);
        temp_in[19:10] = 10'd50;
        step();
        check("alert_sticky", alert, 4'b0010);
        read_frame(3'b100, w4, w3, al4, al3);
        check("alert_word", w4, 10'b0000000010);
        check("alert3_word", w3, 10'b0000000010);
        check("alert_cleared", al4, 4'b0000);
        check("alert3_cleared", al3, 3'b000);
        temp_in[19:10] = 10'd120;
        step();
        check("alert_reset", alert, 4'b0010);
        read_frame(3'b100, w4, w3, al4, al3);
        check("alert_word2", w4, 10'b0000000010);
        check("alert_held", al4, 4'b0010);
        check("alert3_held", al3, 3'b010);

        // Abort after four data bits, then an immediate clean read
        alert_limit = 10'h1FF;
        temp_in = {10'h000, 10'b1101011011, 10'h000, 10'h155};
        send_cmd(3'b010);
        part = '0;
        for (int b = 3; b >= 0; b--) begin
            part[b] = sio;
            step();
        end
        check("abort_bits", part, 10'b0000001101);
        cs = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_sio", sio, 1'b0);
        read_frame(3'b000, w4, w3, al4, al3);
        check("after_abort", w4, 10'h155);

        // Reset in the middle of the data phase
        check("pre_rst_alert", alert, 4'b0010);
        temp_in[19:10] = 10'h2AA;
        send_cmd(3'b001);
        part = '0;
        for (int b = 4; b >= 0; b--) begin
            part[b] = sio;
            step();
        end
        check("rst_mid_bits", part, 10'b0000010101);
        reset = 1'b1;
        step();
        check("rst_mid_sio", sio, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_alert", alert, 4'b0);
        check("rst_mid_alert3", alert3, 3'b0);
        reset = 1'b0; cs = 1'b1;
        step();
        read_frame(3'b010, w4, w3, al4, al3);
        check("after_rst", w4, 10'b1101011011);
        check("after_rst_alert", al4, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_lm07_multi.md
Name: sensor_lm07_multi

Overview:
- Parametrised, multi-channel successor to the single-channel LM07-style serial temperature sensor model.
- Acts as a serial slave clocked by the host serial clock.
- Takes a short command on sdi (channel select plus mode), then shifts the selected channel's two's-complement temperature, or the alert-flag word, MSB first on sio.
- Adds per-channel sticky over-temperature alerts with clear-on-read. Used as the sensor-side model in temperature-controller benches.

Parameters:
- DATA_W, 10: bits per temperature word, two's complement.
- NUM_CH, 4: number of channels, 1..2**CH_W; NUM_CH <= DATA_W required.
- CH_W, 2: width of the channel field in the command.
- CMD_W = CH_W+1: derived. Command length; MSB is the mode bit, remaining bits are the channel.

Ports:
- sclk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; priority over everything.
- cs  input  1  active-low chip select, sampled each sclk edge.
- sdi  input  1  command bit in, sampled MSB first.
- temp_in  input  NUM_CH*DATA_W  channel temperatures; channel i = temp_in[i*DATA_W +: DATA_W].
- alert_limit  input  DATA_W  signed over-temperature threshold, common to all channels.
- sio  output  1  serial data out.
- alert  output  NUM_CH  sticky per-channel over-temperature flags, registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (edge with reset=1):
  - state=IDLE, shift register=0, bit counter=0, alert=0.
  - sio=0, busy=0.
  - Reset is honoured mid-frame and aborts the frame.
- States: IDLE, CMD, DATA, DONE.
  - Any edge with cs=1 forces state to IDLE next. Partial command or data is discarded; alert is still updated.
- IDLE:
  - If cs=0, sample sdi as command bit CMD_W-1, set count=1, go to CMD.
  - Otherwise stay.
- CMD:
  - Each edge shifts sdi into the command register, MSB first.
  - On the edge that samples the CMD_W-th bit, load the shift register and go to DATA, according to the command:
    - mode=0 and channel < NUM_CH: load temp_in of that channel, sampled on that edge.
    - mode=0 and channel >= NUM_CH: load all ones (error pattern).
    - mode=1: load alert flags zero-extended to DATA_W (alert[0] is LSB). The flags loaded are the pre-edge alert values.
- DATA:
  - sio = shift register MSB (combinational from register).
  - Each edge shifts left with 0 fill and increments the count.
  - Lasts exactly DATA_W cycles: bit DATA_W-1 is driven in the first DATA cycle, bit 0 in the last. The edge ending the last cycle goes to DONE.
- DONE: sio=0; stay until cs=1, then IDLE. No second word; sdi is ignored.
- sio = 0 in every state except DATA.
- Latency: the first data bit appears in the cycle after the edge that samples the last command bit.
- Alert, updated every non-reset edge, for each channel i:
  - over_i = signed(temp_in_i) > signed(alert_limit), strictly greater.
  - Default: alert[i] <= alert[i] | over_i (sticky).
  - On a mode-1 load edge: alert[i] <= over_i. This clears the flag unless the channel is still over; a simultaneous set wins.
  - A mode-0 read does not affect alert.
- Widths: the channel field is compared unsigned against NUM_CH. No arithmetic beyond the counters. The counter is wide enough for max(CMD_W, DATA_W).

Test Plan:
1. Reset: hold reset=1 for 2 edges with cs=0 and sdi toggling -> sio=0, busy=0, alert=0; IDLE on release.
2. Read channel 2:
   - Stimulus: ch2=10'b1101011011, cs=0, sdi=0,1,0 on 3 edges.
   - Required: next 10 cycles sio=1,1,0,1,0,1,1,0,1,1, then 0. busy=1 until the edge after cs=1.
3. Out-of-range channel: NUM_CH=3 instance, command 0,1,1 -> sio=1 for 10 cycles, then 0.
4. Alert:
   - alert_limit=100 and ch1=120 -> alert[1]=1 one edge later.
   - ch3=10'h3FB (-5) -> alert[3] stays 0 (signed compare).
   - ch1 drops to 50 -> alert[1] stays 1.
   - Command 1,0,0 -> sio=0000000010; alert[1]=0 after the load edge.
   - Repeat the read with ch1=120 held -> alert[1] remains 1.
5. Abort: cs=1 after 4 data bits -> next edge busy=0, sio=0. An immediate new read of ch0=10'h155 returns 0101010101 intact.
6. Reset mid-DATA: reset=1 at data bit 5 -> IDLE, sio=0, alert cleared. A subsequent frame is correct.
